// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and default operand width for the serial adder
package adder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/bit_serial_adder_fa.sv
// FullAdder: combinational 1-bit full adder cell
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first multi-bit add through one FullAdder with a recirculated carry flop
module bit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_sha;
    logic [WIDTH-1:0] r_shb;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_res_ext;
    logic [WIDTH-1:0] w_res_next;

    FullAdder u_fa (
        .a     (r_sha[0]),
        .b     (r_shb[0]),
        .c     (r_carry),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    assign w_accept   = start && (r_state != RUN);
    assign w_last     = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    // new sum bit enters at the MSB; the slice also covers WIDTH=1
    assign w_res_ext  = {w_fa_sum, r_res};
    assign w_res_next = w_res_ext[WIDTH:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else if (w_accept)
            r_state <= RUN;
        else if (w_last)
            r_state <= DONE;
        else if (r_state == DONE)
            r_state <= IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sha   <= '0;
            r_shb   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_sha   <= a;
            r_shb   <= b;
            r_res   <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sha   <= r_sha >> 1;
            r_shb   <= r_shb >> 1;
            r_res   <= w_res_next;
            r_carry <= w_fa_carry;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_fa_carry;
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Sequential front-end for the `FullAdder` cell. It accepts two WIDTH-bit operands and a carry-in. It then pushes one bit pair per clock, LSB first, through a single `FullAdder` instance, recirculating the carry through a flop. It returns the WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the upstream driver that turns the combinational 1-bit adder into a multi-bit adder for the TT tile top level.

## Interface

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset; clears all state immediately
- start  in  1  request: sampled on a clock edge, honoured only in IDLE or DONE
- a  in  WIDTH  operand A, captured on the accepting edge
- b  in  WIDTH  operand B, captured on the accepting edge
- cin  in  1  carry-in, captured on the accepting edge
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, high exactly while in DONE
- sum  out  WIDTH  registered result; holds the last completed sum
- cout  out  1  registered carry-out of the last completed addition

## Operation

- States: IDLE, RUN, DONE; encoding 2 bits.
- Reset state: IDLE. Reset values:
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flop and bit counter all 0.
- IDLE/DONE with start=1:
  - Load a→shA and b→shB.
  - Load cin→carry flop.
  - Clear the result shift register and set cnt=0.
  - Go to RUN.
- DONE with start=0 → IDLE.
- RUN, each cycle:
  - The FullAdder sees a=shA[0], b=shB[0], c=carry.
  - On the edge, shift shA and shB right by 1 (zero fill).
  - Shift FullAdder.sum into result MSB (result shifts right).
  - carry←FullAdder.carry; cnt←cnt+1.
- RUN exit: on the edge where cnt==WIDTH-1:
  - Commit sum←final shifted result (including this bit) and cout←FullAdder.carry.
  - Go to DONE.
- start in RUN is ignored; operands are not re-captured and no queueing occurs.
- sum and cout change only on the RUN→DONE edge. They are stable at all other times, including during a subsequent RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned only.
- cnt width is $clog2(WIDTH) with a minimum of 1 bit. For WIDTH=1, RUN lasts exactly one cycle.
- Reset mid-RUN: return to IDLE immediately (asynchronously). Zero sum/cout; the partial result is discarded. No done pulse.

## Timing

- Edge E0 accepts start; busy=1 from after E0.
- RUN occupies edges E1..EWIDTH; sum/cout update at EWIDTH.
- done=1 and busy=0 in the cycle after EWIDTH; done returns low after E(WIDTH+1).
- Latency: start accepted to done high is WIDTH+1 edges after E0 counted from E0 inclusive. That is, done is visible WIDTH cycles after busy rises.
- Throughput: start asserted during DONE is accepted at E(WIDTH+1). That gives back-to-back operations every WIDTH+1 cycles. The done pulse is still exactly one cycle.
- Holding start high continuously yields a new operation every WIDTH+1 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure

- Shared package `adder_pkg`: state typedef (IDLE, RUN, DONE) and the WIDTH default constant.
- One sub-module: the existing `FullAdder` (ports a, b, c, sum, carry), instantiated once. No new sub-module.
- Top: one FSM process, one datapath process (shift registers, carry, cnt), and one output-register process.

## Test plan

- WIDTH=8, a=0x3C, b=0x5A, cin=0, start pulse → done after 8 busy cycles; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Pulse start at busy cycle 3 with a=0x01, b=0x01 → ignored; result of the original operation returned; exactly one done pulse.
- Assert rst at busy cycle 4 of a=0x0F+0x0F → busy=0, done=0, sum=0x00, cout=0 immediately. A subsequent a=0x0F+0x0F gives sum=0x1E.
- start held high with a=0x10, b=0x20 then 0x7F, 0x01 changed during DONE:
  - The first done gives sum=0x30.
  - The second operation starts on the same edge that exits DONE; the second done gives sum=0x80, cout=0.
  - Period is 9 cycles.
- Random sweep, WIDTH=1 and WIDTH=8, 1000 operands → {cout,sum} equals a+b+cin for every operation.
